// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's write port (ALU vs load writeback),
// with a per-register pending-write scoreboard used for read-hazard checks.
module regfile_sb_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);
    // A new reservation beats a same-edge commit to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= 1'b0;
        else if (set) q <= 1'b1;
        else if (clr) q <= 1'b0;
    end
endmodule

module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,
    input  logic                   alloc_valid,
    input  logic [ADDR_W-1:0]      alloc_addr,
    output logic                   alloc_err,
    input  logic [ADDR_W-1:0]      chk_a1,
    input  logic [ADDR_W-1:0]      chk_a2,
    output logic                   hz1,
    output logic                   hz2,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [(2**ADDR_W)-1:0] busy
);
    localparam int NREG = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t  r0, r1;
    logic rr;  // 0: req0 wins a tie, 1: req1 wins a tie
    logic gnt0, gnt1;

    assign r0 = '{addr: req0_addr, data: req0_data};
    assign r1 = '{addr: req1_addr, data: req1_data};

    assign gnt0 = !rst && req0_valid && (!req1_valid || !rr);
    assign gnt1 = !rst && req1_valid && (!req0_valid ||  rr);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr        <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            alloc_err <= 1'b0;
        end else begin
            if (req0_valid && req1_valid) rr <= ~rr;
            rf_we <= gnt0 | gnt1;
            if (gnt0) begin
                rf_waddr <= r0.addr;
                rf_wdata <= r0.data;
            end else if (gnt1) begin
                rf_waddr <= r1.addr;
                rf_wdata <= r1.data;
            end
            alloc_err <= alloc_valid && busy[alloc_addr];
        end
    end

    // Scoreboard: set on reservation, clear on the commit edge of the write.
    logic [NREG-1:0] set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (alloc_valid) set_vec[alloc_addr] = 1'b1;
        if (rf_we)       clr_vec[rf_waddr]   = 1'b1;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_sb
        regfile_sb_cell u_cell (
            .clk (clk),
            .rst (rst),
            .set (set_vec[i]),
            .clr (clr_vec[i]),
            .q   (busy[i])
        );
    end

    assign hz1 = busy[chk_a1];
    assign hz2 = busy[chk_a2];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset corners, and
// randomized traffic checked against a cycle-level reference model.
module tb_regfile_write_arbiter;
    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req1_valid = 0, alloc_valid = 0;
    logic [3:0]  req0_addr = 0, req1_addr = 0, alloc_addr = 0, chk_a1 = 0, chk_a2 = 0;
    logic [31:0] req0_data = 0, req1_data = 0;
    logic        req0_ready, req1_ready, alloc_err, hz1, hz2, rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] busy;

    int nchk = 0, nerr = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_err(alloc_err),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .hz1(hz1), .hz2(hz2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file stand-in: commits on the edge after the write is presented.
    logic [31:0] rfm [16];
    always @(posedge clk) if (rf_we) rfm[rf_waddr] <= rf_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic r0v; logic [3:0] r0a; logic [31:0] r0d;
        logic r1v; logic [3:0] r1a; logic [31:0] r1d;
        logic av;  logic [3:0] aa;
        logic rdy0, rdy1, h1, h2;
        logic we; logic [3:0] wa; logic [31:0] wd; logic [15:0] bsy; logic err;
    } vec_t;

    function automatic vec_t mk(logic r0v, logic [3:0] r0a, logic [31:0] r0d,
                                logic r1v, logic [3:0] r1a, logic [31:0] r1d,
                                logic av, logic [3:0] aa,
                                logic rdy0, logic rdy1, logic h1, logic h2,
                                logic we, logic [3:0] wa, logic [31:0] wd,
                                logic [15:0] bsy, logic err);
        vec_t v;
        v.r0v = r0v; v.r0a = r0a; v.r0d = r0d; v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
        v.av = av; v.aa = aa; v.rdy0 = rdy0; v.rdy1 = rdy1; v.h1 = h1; v.h2 = h2;
        v.we = we; v.wa = wa; v.wd = wd; v.bsy = bsy; v.err = err;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1;
        req0_valid = 0; req1_valid = 0; alloc_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
    endtask

    // Reference model state
    int          m_pref;
    logic [15:0] m_busy;
    logic        m_we, m_err;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;

    vec_t tbl[15];

    initial begin
        int g;
        logic [15:0] nb;

        //          r0v r0a r0d     r1v r1a r1d     av aa  rdy0 rdy1 h1 h2  we wa wd      busy     err
        tbl[0]  = mk(1, 2, 32'hF,   0, 0, 0,        0, 0,  1, 0, 0, 0,      1, 2, 32'hF,  16'h0,   0);
        tbl[1]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0, 0, 0,      0, 2, 32'hF,  16'h0,   0);
        tbl[2]  = mk(1, 3, 32'hA,   1, 7, 32'hB,    0, 0,  1, 0, 0, 0,      1, 3, 32'hA,  16'h0,   0);
        tbl[3]  = mk(1, 3, 32'hA,   1, 7, 32'hB,    0, 0,  0, 1, 0, 0,      1, 7, 32'hB,  16'h0,   0);
        tbl[4]  = mk(1, 3, 32'hA,   1, 7, 32'hB,    0, 0,  1, 0, 0, 0,      1, 3, 32'hA,  16'h0,   0);
        tbl[5]  = mk(1, 3, 32'hA,   1, 7, 32'hB,    0, 0,  0, 1, 0, 0,      1, 7, 32'hB,  16'h0,   0);
        tbl[6]  = mk(0, 0, 0,       0, 0, 0,        1, 5,  0, 0, 0, 0,      0, 7, 32'hB,  16'h20,  0);
        tbl[7]  = mk(0, 0, 0,       1, 5, 32'h55,   0, 0,  0, 1, 1, 0,      1, 5, 32'h55, 16'h20,  0);
        tbl[8]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0, 1, 0,      0, 5, 32'h55, 16'h0,   0);
        tbl[9]  = mk(1, 5, 32'h66,  0, 0, 0,        1, 5,  1, 0, 0, 0,      1, 5, 32'h66, 16'h20,  0);
        tbl[10] = mk(0, 0, 0,       0, 0, 0,        1, 5,  0, 0, 1, 0,      0, 5, 32'h66, 16'h20,  1);
        tbl[11] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0, 1, 0,      0, 5, 32'h66, 16'h20,  0);
        tbl[12] = mk(0, 0, 0,       0, 0, 0,        1, 4,  0, 0, 1, 0,      0, 5, 32'h66, 16'h30,  0);
        tbl[13] = mk(0, 0, 0,       0, 0, 0,        1, 4,  0, 0, 1, 1,      0, 5, 32'h66, 16'h30,  1);
        tbl[14] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0, 1, 1,      0, 5, 32'h66, 16'h30,  0);

        // Reset with both sources requesting: nothing accepted.
        req0_valid = 1; req1_valid = 1; req0_addr = 1; req1_addr = 2;
        repeat (2) @(negedge clk);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", alloc_err, 0);
        rst = 0; #1;
        chk("post_rst_rdy0", req0_ready, 1);
        chk("post_rst_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        chk("idle_we", rf_we, 0);

        chk_a1 = 5; chk_a2 = 4;
        for (int i = 0; i < 15; i++) begin
            req0_valid = tbl[i].r0v; req0_addr = tbl[i].r0a; req0_data = tbl[i].r0d;
            req1_valid = tbl[i].r1v; req1_addr = tbl[i].r1a; req1_data = tbl[i].r1d;
            alloc_valid = tbl[i].av; alloc_addr = tbl[i].aa;
            @(negedge clk);
            chk($sformatf("v%0d_rdy0", i), req0_ready, tbl[i].rdy0);
            chk($sformatf("v%0d_rdy1", i), req1_ready, tbl[i].rdy1);
            chk($sformatf("v%0d_hz1", i), hz1, tbl[i].h1);
            chk($sformatf("v%0d_hz2", i), hz2, tbl[i].h2);
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].wa);
            chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d_err", i), alloc_err, tbl[i].err);
            if (i == 1) chk("rf_r2", rfm[2], 32'hF);
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_pref = 0; m_busy = 0; m_we = 0; m_err = 0; m_wa = 0; m_wd = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = 1'($urandom_range(0, 1)); req0_addr = 4'($urandom_range(0, 7)); req0_data = $urandom;
            req1_valid = 1'($urandom_range(0, 1)); req1_addr = 4'($urandom_range(0, 7)); req1_data = $urandom;
            alloc_valid = ($urandom_range(0, 2) == 0); alloc_addr = 4'($urandom_range(0, 7));
            chk_a1 = 4'($urandom_range(0, 15)); chk_a2 = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (req0_valid && req1_valid) begin g = m_pref; m_pref = 1 - m_pref; end
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
            else g = -1;
            chk("rnd_rdy0", req0_ready, g == 0);
            chk("rnd_rdy1", req1_ready, g == 1);
            chk("rnd_hz1", hz1, m_busy[chk_a1]);
            chk("rnd_hz2", hz2, m_busy[chk_a2]);
            @(posedge clk); #1;
            nb = m_busy;
            if (m_we) nb[m_wa] = 1'b0;
            if (alloc_valid) nb[alloc_addr] = 1'b1;
            m_err = alloc_valid && m_busy[alloc_addr];
            m_busy = nb;
            m_we = (g >= 0);
            if (g == 0) begin m_wa = req0_addr; m_wd = req0_data; end
            if (g == 1) begin m_wa = req1_addr; m_wd = req1_data; end
            chk("rnd_we", rf_we, m_we);
            chk("rnd_waddr", rf_waddr, m_wa);
            chk("rnd_wdata", rf_wdata, m_wd);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_err", alloc_err, m_err);
        end

        // Asynchronous reset in the middle of a write with a pending error pulse.
        do_reset();
        req1_valid = 0;
        req0_valid = 1; req0_addr = 1; req0_data = 32'h1234;
        alloc_valid = 1; alloc_addr = 4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_arst_we", rf_we, 1);
        chk("pre_arst_err", alloc_err, 1);
        chk("pre_arst_busy", busy, 16'h10);
        rst = 1; #1;
        chk("arst_we", rf_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", alloc_err, 0);
        chk("arst_waddr", rf_waddr, 0);
        chk("arst_rdy0", req0_ready, 0);
        req0_valid = 0; alloc_valid = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
